// File: rtl/calibration_sequencer.sv
// calibration_sequencer: start -> DC offset -> settle -> IR record -> convolution enable.
// Define CALIBRATION_SEQ_TIMEOUT_EN to add wait-state timeouts and the FAULT state.
module calibration_sequencer #(
    parameter int SETTLE_SAMPLES  = 2400,
    parameter int TIMEOUT_SAMPLES = 48000
) (
    input  logic       audio_clk,
    input  logic       rst_in,
    input  logic       audio_trigger,
    input  logic       start,
    input  logic       abort,
    input  logic       offset_produced,
    input  logic       impulse_recorded,
    output logic       offset_trigger,
    output logic       record_impulse_trigger,
    output logic       conv_enable,
    output logic       busy,
    output logic       error,
    output logic [2:0] state_out
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        OFF_REQ  = 3'd1,
        OFF_WAIT = 3'd2,
        SETTLE   = 3'd3,
        IR_REQ   = 3'd4,
        IR_WAIT  = 3'd5,
        RUN      = 3'd6,
        FAULT    = 3'd7
    } state_t;

`ifdef CALIBRATION_SEQ_TIMEOUT_EN
    localparam int CNT_MAX = (SETTLE_SAMPLES > TIMEOUT_SAMPLES) ? SETTLE_SAMPLES : TIMEOUT_SAMPLES;
`else
    localparam int CNT_MAX = SETTLE_SAMPLES;
`endif
    localparam int W = $clog2(CNT_MAX + 1);
    localparam logic [W-1:0] SETTLE_LAST = W'(SETTLE_SAMPLES - 1);

    if (SETTLE_SAMPLES < 1 || TIMEOUT_SAMPLES < 1) begin : g_bad_params
        $error("calibration_sequencer: SETTLE_SAMPLES and TIMEOUT_SAMPLES must be >= 1");
    end

    state_t         state, state_next;
    logic [W-1:0]   cnt;
    logic           ir_prev, ir_rise, counting, timeout;

    // Only a fresh rise counts, so a level left high from an earlier run is ignored.
    assign ir_rise  = impulse_recorded & ~ir_prev;
    assign counting = audio_trigger && (state == SETTLE || state == OFF_WAIT || state == IR_WAIT);

`ifdef CALIBRATION_SEQ_TIMEOUT_EN
    localparam logic [W-1:0] TIMEOUT_CNT = W'(TIMEOUT_SAMPLES);
    assign timeout = (state == OFF_WAIT || state == IR_WAIT) && cnt == TIMEOUT_CNT;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            state   <= IDLE;
            cnt     <= '0;
            ir_prev <= 1'b0;
        end else begin
            state   <= state_next;
            ir_prev <= impulse_recorded;
            cnt     <= (state_next != state) ? '0 : (counting && cnt != '1) ? cnt + 1'b1 : cnt;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, RUN, FAULT: state_next = start ? OFF_REQ : state;
            OFF_REQ:          state_next = OFF_WAIT;
            OFF_WAIT:         state_next = offset_produced ? SETTLE : timeout ? FAULT : OFF_WAIT;
            SETTLE:           state_next = (audio_trigger && cnt == SETTLE_LAST) ? IR_REQ : SETTLE;
            IR_REQ:           state_next = IR_WAIT;
            IR_WAIT:          state_next = ir_rise ? RUN : timeout ? FAULT : IR_WAIT;
        endcase
        if (abort)
            state_next = IDLE;
    end

    always_comb begin
        offset_trigger         = state == OFF_REQ;
        record_impulse_trigger = state == IR_REQ;
        conv_enable            = state == RUN;
        busy                   = !(state == IDLE || state == RUN || state == FAULT);
`ifdef CALIBRATION_SEQ_TIMEOUT_EN
        error                  = state == FAULT;
`else
        error                  = 1'b0;
`endif
        state_out              = state;
    end
endmodule

// File: tb/tb_calibration_sequencer.sv
// tb_calibration_sequencer: vector table plus scoreboarded multi-cycle scenarios.
module tb_calibration_sequencer;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 10;

    logic       audio_clk = 1'b0;
    logic       rst_in = 1'b1, audio_trigger = 1'b0, start = 1'b0, abort = 1'b0;
    logic       offset_produced = 1'b0, impulse_recorded = 1'b0;
    logic       offset_trigger, record_impulse_trigger, conv_enable, busy, error;
    logic [2:0] state_out;
    logic [7:0] act;
    logic       ir_lvl = 1'b0;
    int         checks = 0, fails = 0, tick = 0;

    always #5 audio_clk = ~audio_clk;

    calibration_sequencer #(.SETTLE_SAMPLES(SETTLE), .TIMEOUT_SAMPLES(TIMEOUT)) dut (
        .audio_clk(audio_clk), .rst_in(rst_in), .audio_trigger(audio_trigger), .start(start),
        .abort(abort), .offset_produced(offset_produced), .impulse_recorded(impulse_recorded),
        .offset_trigger(offset_trigger), .record_impulse_trigger(record_impulse_trigger),
        .conv_enable(conv_enable), .busy(busy), .error(error), .state_out(state_out)
    );

    assign act = {offset_trigger, record_impulse_trigger, conv_enable, busy, error, state_out};

    typedef struct {
        string      nm;
        logic [7:0] exp;
    } sb_t;
    sb_t sb[$];

    // Field order: {start, abort, offset_produced, impulse_recorded, audio_trigger}_{expected state}
    typedef struct packed {
        logic       st, ab, op, ir, at;
        logic [2:0] exp;
    } vec_t;
    vec_t vecs[23] = '{
        8'b00100_000, 8'b01000_000, 8'b11000_000, 8'b10000_001, 8'b10000_010,
        8'b10000_010, 8'b00001_010, 8'b00100_011, 8'b00100_011, 8'b00001_011,
        8'b10001_011, 8'b00001_011, 8'b00000_011, 8'b00001_100, 8'b00010_101,
        8'b00010_101, 8'b00000_101, 8'b00010_110, 8'b00110_110, 8'b10010_001,
        8'b00010_010, 8'b01110_000, 8'b00000_000
    };

    function automatic logic [7:0] dec(input logic [2:0] s);
        return {s == 3'd1, s == 3'd4, s == 3'd6, !(s == 3'd0 || s == 3'd6 || s == 3'd7), s == 3'd7, s};
    endfunction

    function automatic int per();
        return (tick % 8 == 7) ? 1 : 0;
    endfunction

    task automatic cyc(input int rs, st, ab, op, at, exp_st, input string nm);
        sb_t e;
        rst_in = rs != 0; start = st != 0; abort = ab != 0;
        offset_produced = op != 0; audio_trigger = at != 0; impulse_recorded = ir_lvl;
        sb.push_back('{nm, dec(3'(exp_st))});
        @(posedge audio_clk); #1;
        tick++;
        rst_in = 1'b0; start = 1'b0; abort = 1'b0; offset_produced = 1'b0; audio_trigger = 1'b0;
        e = sb.pop_front();
        checks++;
        if (act !== e.exp) begin
            fails++;
            $display("FAIL %s: got {otrig,rtrig,conv,busy,err,state}=%b want %b", e.nm, act, e.exp);
        end
    endtask

    task automatic expire(input string nm);
        checks++;
        fails++;
        $display("FAIL %s: cycle bound expired", nm);
    endtask

    // Periodic strobes in SETTLE; the SETTLE-th one must produce IR_REQ.
    task automatic settle(input string nm);
        int n = 0, a, e;
        for (int i = 0; i < 64; i++) begin
            a = per();
            e = (a != 0 && n == SETTLE - 1) ? 4 : 3;
            cyc(0, 0, 0, 0, a, e, nm);
            if (a != 0) n++;
            if (e == 4) return;
        end
        expire(nm);
    endtask

`ifdef CALIBRATION_SEQ_TIMEOUT_EN
    // Counter reaches TIMEOUT on a strobe; FAULT appears one cycle after that.
    task automatic to_wait(input int cur, input string nm);
        int n = 0, a, e;
        for (int i = 0; i < 200; i++) begin
            a = per();
            e = (n == TIMEOUT) ? 7 : cur;
            cyc(0, 0, 0, 0, a, e, nm);
            if (e == 7) return;
            if (a != 0) n++;
        end
        expire(nm);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(1, 0, 0, 0, 0, 0, "reset");
        for (int i = 0; i < 23; i++) begin
            ir_lvl = vecs[i].ir;
            cyc(0, vecs[i].st, vecs[i].ab, vecs[i].op, vecs[i].at, vecs[i].exp, $sformatf("vec%0d", i));
        end
        ir_lvl = 1'b0;

        cyc(0, 1, 0, 0, per(), 1, "hp_off_req");
        for (int i = 0; i < 19; i++) cyc(0, 0, 0, 0, per(), 2, "hp_off_wait");
        cyc(0, 0, 0, 1, per(), 3, "hp_settle_entry");
        settle("hp_settle");
        cyc(0, 0, 0, 0, per(), 5, "hp_ir_req");
        for (int i = 0; i < 49; i++) cyc(0, 0, 0, 0, per(), 5, "hp_ir_wait");
        ir_lvl = 1'b1;
        cyc(0, 0, 0, 0, per(), 6, "hp_run_entry");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, per(), 6, "hp_run_hold");
        cyc(0, 0, 1, 0, 0, 0, "hp_abort_run");
        ir_lvl = 1'b0;

        cyc(0, 1, 0, 0, 0, 1, "mr_off_req");
        cyc(0, 0, 0, 0, 0, 2, "mr_off_wait");
        cyc(0, 0, 0, 1, 0, 3, "mr_settle");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 3, "mr_count");
        cyc(1, 0, 0, 0, 0, 0, "mr_reset");
        cyc(0, 1, 0, 0, 0, 1, "mr2_off_req");
        cyc(0, 0, 0, 0, 0, 2, "mr2_off_wait");
        cyc(0, 0, 0, 1, 0, 3, "mr2_settle");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 3, "mr2_count_cleared");
        cyc(0, 0, 0, 0, 1, 4, "mr2_ir_req");
        cyc(0, 0, 0, 0, 0, 5, "mr2_ir_wait");
        cyc(0, 0, 1, 0, 0, 0, "mr2_abort");

        ir_lvl = 1'b1;
        cyc(0, 1, 0, 0, per(), 1, "st_off_req");
        cyc(0, 0, 0, 0, per(), 2, "st_off_wait");
        cyc(0, 0, 0, 1, per(), 3, "st_settle_entry");
        settle("st_settle");
        cyc(0, 0, 0, 0, per(), 5, "st_ir_req");
`ifdef CALIBRATION_SEQ_TIMEOUT_EN
        to_wait(5, "st_timeout");
        cyc(0, 1, 0, 0, 0, 1, "st_fault_restart");
        cyc(0, 0, 1, 0, 0, 0, "st_abort");
`else
        for (int i = 0; i < 40; i++) cyc(0, 0, 0, 0, per(), 5, "st_ir_wait_hold");
        cyc(0, 0, 1, 0, 0, 0, "st_abort");
`endif
        ir_lvl = 1'b0;

`ifdef CALIBRATION_SEQ_TIMEOUT_EN
        cyc(0, 1, 0, 0, per(), 1, "to_off_req");
        cyc(0, 0, 0, 0, per(), 2, "to_off_wait");
        to_wait(2, "to_timeout");
        cyc(0, 0, 0, 1, 0, 7, "to_stray_offset");
        cyc(0, 1, 0, 0, 0, 1, "to_restart");
        cyc(0, 0, 0, 0, 0, 2, "to_off_wait2");
        cyc(0, 0, 1, 0, 0, 0, "to_abort");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/calibration_sequencer.md
# calibration_sequencer

Sequences room calibration for the convolution reverb path. On one start request it triggers DC-offset measurement and waits for the offset to be produced. It then lets the acoustic path settle, triggers impulse-response recording, waits for the recording to finish, and enables convolution. It sits between the button/switch front end and the `calculate_offset`, `record_impulse` and `convolve_audio` blocks, and replaces their independent manual triggers.

## Interface
- `SETTLE_SAMPLES`, default 2400: sample strobes to wait between offset capture and impulse trigger (100 ms at 24 kHz); must be ≥1.
- `TIMEOUT_SAMPLES`, default 48000: maximum sample strobes spent in any wait state; must be ≥1.

Clock and reset: one clock; reset is synchronous and active-high.

- `audio_clk`  in  1  system audio clock (98.3 MHz).
- `rst_in`  in  1  synchronous, active-high reset.
- `audio_trigger`  in  1  single-cycle 24 kHz sample strobe.
- `start`  in  1  single-cycle calibration request (already edge-detected).
- `abort`  in  1  single-cycle cancel.
- `offset_produced`  in  1  single-cycle pulse from the offset calculator.
- `impulse_recorded`  in  1  level, high once the IR is in memory.
- `offset_trigger`  out  1  single-cycle pulse to the offset calculator.
- `record_impulse_trigger`  out  1  single-cycle pulse to the IR recorder.
- `conv_enable`  out  1  high while calibration is complete and valid.
- `busy`  out  1  high in every state except IDLE, RUN and FAULT.
- `error`  out  1  high in FAULT.
- `state_out`  out  3  current state encoding, for the seven-segment display.

## Operation
- States and encodings: IDLE=0, OFF_REQ=1, OFF_WAIT=2, SETTLE=3, IR_REQ=4, IR_WAIT=5, RUN=6, FAULT=7.
- IDLE, RUN, FAULT:
  - `start` → OFF_REQ.
  - Otherwise hold.
- OFF_REQ → OFF_WAIT unconditionally; `offset_trigger` is high only in OFF_REQ.
- OFF_WAIT:
  - `offset_produced` → SETTLE.
  - Timeout → FAULT.
- SETTLE: counts `audio_trigger` strobes; after the `SETTLE_SAMPLES`-th strobe → IR_REQ.
- IR_REQ → IR_WAIT unconditionally; `record_impulse_trigger` is high only in IR_REQ.
- IR_WAIT:
  - A rising edge of `impulse_recorded` (compared with its value one cycle earlier) → RUN.
  - A level that is already high on entry does not count.
  - Timeout → FAULT.
- Outputs:
  - `conv_enable` = (state==RUN); `error` = (state==FAULT).
  - All outputs decode from the state register only; no input-to-output combinational path.
- Counter:
  - One shared counter, width $clog2(max(SETTLE_SAMPLES,TIMEOUT_SAMPLES)+1).
  - Cleared on every state change.
  - Incremented on `audio_trigger` in SETTLE, OFF_WAIT and IR_WAIT.
  - Saturates, never wraps.
- Timeout means the counter equals `TIMEOUT_SAMPLES` in OFF_WAIT or IR_WAIT.
- Priorities, highest first:
  1. `rst_in`.
  2. `abort`, which sends any non-IDLE state to IDLE and drops `conv_enable`.
  3. The completion event (`offset_produced` or the rising edge of `impulse_recorded`).
  4. Timeout.
  5. `start`.
- `start` is ignored while `busy`.
- `start` in RUN restarts calibration; `conv_enable` falls on the same edge that enters OFF_REQ.
- A stray `offset_produced` or `impulse_recorded` edge outside its wait state is ignored.

## Timing
- Reset:
  - State IDLE, counter 0, edge-detect register 0.
  - All outputs 0 and `state_out`=0 on the cycle after `rst_in` is sampled high.
- `start` at cycle t (from IDLE): OFF_REQ and `offset_trigger` high at t+1; OFF_WAIT at t+2.
- `offset_produced` at cycle u: SETTLE at u+1.
- SETTLE exit: the `SETTLE_SAMPLES`-th strobe at cycle v gives IR_REQ at v+1 and IR_WAIT at v+2.
- `impulse_recorded` rising at cycle w (first cycle high): RUN and `conv_enable` high at w+1.
- Trigger pulses last exactly one `audio_clk` cycle.
- Timeout: the strobe bringing the counter to `TIMEOUT_SAMPLES` at cycle x gives FAULT at x+2 (count registered at x+1, compared at x+1).
- `abort` at cycle a: IDLE at a+1.

## Configuration
- `CALIBRATION_SEQ_TIMEOUT_EN` defined: timeout logic is present as specified.
- Undefined:
  - OFF_WAIT and IR_WAIT wait indefinitely.
  - FAULT is unreachable and `error` is tied to 0.
  - The counter is only used by SETTLE and is sized from `SETTLE_SAMPLES` alone.

## Test plan
All scenarios use SETTLE_SAMPLES=4, TIMEOUT_SAMPLES=10, and `audio_trigger` every 8 clocks.

- Happy path:
  - Stimulus: `start`; `offset_produced` 20 cycles later; `impulse_recorded` rises 50 cycles after IR_REQ.
  - Required: one `offset_trigger` pulse; IR_REQ one cycle after the 4th strobe in SETTLE; one `record_impulse_trigger` pulse; `conv_enable`=1 one cycle after the rise.
- Timeout (macro defined):
  - Stimulus: no `offset_produced`.
  - Required: FAULT (`state_out`=7, `error`=1) two cycles after the 10th strobe; a following `start` clears `error` and returns to OFF_REQ.
- Abort precedence:
  - Stimulus: `abort` and `offset_produced` in the same cycle in OFF_WAIT.
  - Required: IDLE next cycle; no SETTLE.
- Stale level:
  - Stimulus: `impulse_recorded` held high through the whole run.
  - Required: the FSM stays in IR_WAIT until timeout; no `conv_enable`.
- Restart from RUN:
  - Stimulus: `start` while `conv_enable`=1.
  - Required: `conv_enable`=0 and `offset_trigger`=1 on the same cycle; `start` while busy has no effect.
- Mid-operation reset:
  - Stimulus: `rst_in` in SETTLE with counter=3.
  - Required: IDLE, counter 0 and all outputs 0 the next cycle.
